ervp_tick_timer: RTL and testbench

- Consumer-side counterpart of the system tick generator.
- Takes the shared tick_1us / tick_62d5ms strobes and provides a programmable one-shot or periodic timeout with start/stop/clear control, a sticky expiry flag and a one-cycle expiry pulse.
- Sits in the common peripheral group behind a register-interface wrapper.
- One instance per timer channel; all instances share the single tick generator.

---
 rtl/ervp_tick_timer_pkg.sv | 17 +
 rtl/ervp_tick_timer_if.sv | 29 ++
 rtl/ervp_tick_timer_dcnt.sv | 35 +++
 rtl/ervp_tick_timer.sv | 84 ++++++++
 tb/tb_ervp_tick_timer.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/ervp_tick_timer_pkg.sv
// Shared constants for the tick-driven timeout channel.
package ervp_tick_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic UNIT_1US    = 1'b0;
    localparam logic UNIT_62D5MS = 1'b1;

    // Command priority within one cycle, highest first:
    //   stop (when armed or done) > start (timeout != 0) > expiring tick > clear.
    // An expiry still sets expired even when clear is asserted alongside it.

endpackage

// File: rtl/ervp_tick_timer_if.sv
// Control/status bundle between the register wrapper and one timer channel.
interface ervp_tick_timer_if #(
    parameter int BW_TIMEOUT = 16
);
    logic                  tick_1us;
    logic                  tick_62d5ms;
    logic                  cfg_unit;
    logic                  cfg_periodic;
    logic [BW_TIMEOUT-1:0] cfg_timeout;
    logic                  start;
    logic                  stop;
    logic                  clear;
    logic                  busy;
    logic                  expired;
    logic                  expire_pulse;
    logic [BW_TIMEOUT-1:0] remaining;

    modport master (
        output tick_1us, tick_62d5ms, cfg_unit, cfg_periodic, cfg_timeout,
               start, stop, clear,
        input  busy, expired, expire_pulse, remaining
    );

    modport slave (
        input  tick_1us, tick_62d5ms, cfg_unit, cfg_periodic, cfg_timeout,
               start, stop, clear,
        output busy, expired, expire_pulse, remaining
    );
endinterface

// File: rtl/ervp_tick_timer_dcnt.sv
// Loadable down-counter; clear beats load beats decrement.
module ervp_tick_timer_dcnt #(
    parameter int BW = 16
) (
    input  logic          clk,
    input  logic          rstnn,
    input  logic          clr_i,
    input  logic          load_i,
    input  logic [BW-1:0] load_val_i,
    input  logic          dec_i,
    output logic [BW-1:0] cnt_o,
    output logic          is_one_o
);
    logic [BW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (load_i)
            cnt_d = load_val_i;
        else if (dec_i && (cnt_q != '0))
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o    = cnt_q;
    assign is_one_o = (cnt_q == BW'(1));
endmodule

// File: rtl/ervp_tick_timer.sv
// One timer channel: one-shot or periodic timeout counted in shared ticks.
module ervp_tick_timer
    import ervp_tick_timer_pkg::*;
#(
    parameter int BW_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rstnn,
    ervp_tick_timer_if.slave  bus
);
    state_e                state_q, state_d;
    logic                  unit_q, periodic_q;
    logic [BW_TIMEOUT-1:0] timeout_q;
    logic                  expired_q, expired_d;
    logic                  pulse_q;

    logic                  sel_tick, start_ok, stop_ok, tick_run, expiring;
    logic                  cnt_clr, cnt_load, cnt_dec, is_one;
    logic [BW_TIMEOUT-1:0] cnt_val, load_val;

    assign sel_tick = (unit_q == UNIT_62D5MS) ? bus.tick_62d5ms : bus.tick_1us;
    assign start_ok = bus.start && !bus.stop && (bus.cfg_timeout != '0);
    assign stop_ok  = bus.stop && (state_q != IDLE);
    // A tick only counts when no command claims this cycle.
    assign tick_run = (state_q == RUN) && sel_tick && !start_ok && !stop_ok;
    assign expiring = tick_run && is_one;

    assign cnt_clr  = stop_ok || (expiring && !periodic_q);
    assign cnt_load = start_ok || (expiring && periodic_q);
    assign load_val = start_ok ? bus.cfg_timeout : timeout_q;
    assign cnt_dec  = tick_run && !is_one;

    ervp_tick_timer_dcnt #(.BW(BW_TIMEOUT)) u_dcnt (
        .clk        (clk),
        .rstnn      (rstnn),
        .clr_i      (cnt_clr),
        .load_i     (cnt_load),
        .load_val_i (load_val),
        .dec_i      (cnt_dec),
        .cnt_o      (cnt_val),
        .is_one_o   (is_one)
    );

    always_comb begin
        state_d = state_q;
        if (start_ok)
            state_d = RUN;
        else if (stop_ok)
            state_d = IDLE;
        else if (expiring && !periodic_q)
            state_d = DONE;

        expired_d = expired_q;
        if (expiring)
            expired_d = 1'b1;
        else if (bus.clear)
            expired_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_q    <= IDLE;
            unit_q     <= UNIT_1US;
            periodic_q <= 1'b0;
            timeout_q  <= '0;
            expired_q  <= 1'b0;
            pulse_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            expired_q <= expired_d;
            pulse_q   <= expiring;
            if (start_ok) begin
                unit_q     <= bus.cfg_unit;
                periodic_q <= bus.cfg_periodic;
                timeout_q  <= bus.cfg_timeout;
            end
        end
    end

    assign bus.busy         = (state_q == RUN);
    assign bus.expired      = expired_q;
    assign bus.expire_pulse = pulse_q;
    assign bus.remaining    = cnt_val;
endmodule

// File: tb/tb_ervp_tick_timer.sv
// Scoreboard bench for ervp_tick_timer: behavioural model predicts each cycle.
module tb_ervp_tick_timer;
    localparam int BW = 16;

    typedef struct packed {
        logic          busy;
        logic          expired;
        logic          pulse;
        logic [BW-1:0] rem;
    } exp_t;

    logic clk, rstnn;
    int   vectors, miscompares, npulse;
    exp_t sbq[$];

    int          m_state;
    logic        m_unit, m_per, m_exp, m_pulse;
    int          m_to, m_rem;

    ervp_tick_timer_if #(.BW_TIMEOUT(BW)) tif ();

    ervp_tick_timer #(.BW_TIMEOUT(BW)) dut (
        .clk   (clk),
        .rstnn (rstnn),
        .bus   (tif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_unit = 0; m_per = 0; m_exp = 0; m_pulse = 0; m_to = 0; m_rem = 0;
    endtask

    task automatic step(input string tag, input logic t1, input logic t62,
                        input logic st, input logic sp, input logic cl);
        logic sel, expd;
        exp_t e, o;
        tif.tick_1us = t1; tif.tick_62d5ms = t62;
        tif.start = st; tif.stop = sp; tif.clear = cl;
        sel = m_unit ? t62 : t1;
        expd = 1'b0;
        m_pulse = 1'b0;
        if (sp && m_state != 0) begin
            m_state = 0; m_rem = 0;
        end else if (st && !sp && tif.cfg_timeout != 0) begin
            m_unit = tif.cfg_unit; m_per = tif.cfg_periodic; m_to = int'(tif.cfg_timeout);
            m_state = 1; m_rem = m_to;
        end else if (m_state == 1 && sel) begin
            if (m_rem == 1) begin
                expd = 1'b1; m_pulse = 1'b1; m_exp = 1'b1;
                if (m_per) m_rem = m_to;
                else begin m_rem = 0; m_state = 2; end
            end else begin
                m_rem = m_rem - 1;
            end
        end
        if (cl && !expd) m_exp = 1'b0;
        e.busy = (m_state == 1); e.expired = m_exp; e.pulse = m_pulse; e.rem = BW'(m_rem);
        sbq.push_back(e);
        @(posedge clk);
        #1;
        o = sbq.pop_front();
        chk({tag, ".busy"},    32'(tif.busy),         32'(o.busy));
        chk({tag, ".expired"}, 32'(tif.expired),      32'(o.expired));
        chk({tag, ".pulse"},   32'(tif.expire_pulse), 32'(o.pulse));
        chk({tag, ".rem"},     32'(tif.remaining),    32'(o.rem));
        if (tif.expire_pulse) npulse++;
        tif.tick_1us = 0; tif.tick_62d5ms = 0; tif.start = 0; tif.stop = 0; tif.clear = 0;
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 0, 0);
    endtask

    task automatic cfg(input logic unit, input logic per, input int to);
        tif.cfg_unit = unit; tif.cfg_periodic = per; tif.cfg_timeout = BW'(to);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".busy"},    32'(tif.busy),         0);
        chk({tag, ".expired"}, 32'(tif.expired),      0);
        chk({tag, ".pulse"},   32'(tif.expire_pulse), 0);
        chk({tag, ".rem"},     32'(tif.remaining),    0);
    endtask

    initial begin
        vectors = 0; miscompares = 0; npulse = 0;
        model_reset();
        tif.tick_1us = 0; tif.tick_62d5ms = 0; tif.start = 0; tif.stop = 0; tif.clear = 0;
        cfg(0, 0, 0);
        rstnn = 1'b0;
        #12;
        check_zero("reset");
        rstnn = 1'b1;

        // one-shot, 1 us unit, tick every 10 clk
        cfg(0, 0, 5);
        step("os_start", 0, 0, 1, 0, 0);
        npulse = 0;
        for (int k = 0; k < 5; k++) begin
            step("os_tick", 1, 0, 0, 0, 0);
            idle("os_gap", 9);
        end
        for (int k = 0; k < 3; k++) begin
            step("os_post", 1, 0, 0, 0, 0);
            idle("os_post", 4);
        end
        chk("os_npulse", npulse, 1);

        // periodic, 62.5 ms unit; 1 us ticks must be ignored
        cfg(1, 1, 3);
        step("per_start", 0, 0, 1, 0, 0);
        cfg(0, 0, 9);
        npulse = 0;
        for (int k = 0; k < 9; k++) begin
            step("per_tick", 0, 1, 0, 0, 0);
            step("per_1us", 1, 0, 0, 0, 0);
            idle("per_gap", 2);
        end
        chk("per_npulse", npulse, 3);
        step("per_stop", 0, 0, 0, 1, 0);
        step("per_clr", 0, 0, 0, 0, 1);

        // stop collides with the expiring tick
        cfg(0, 0, 2);
        step("sc_start", 0, 0, 1, 0, 0);
        step("sc_tick", 1, 0, 0, 0, 0);
        npulse = 0;
        step("sc_coll", 1, 0, 0, 1, 0);
        idle("sc_after", 2);
        chk("sc_npulse", npulse, 0);
        step("sc_idle_stop", 0, 0, 0, 1, 0);

        // clear collides with a periodic expiry, then a lone clear
        cfg(0, 1, 2);
        step("cc_start", 0, 0, 1, 0, 0);
        step("cc_t1", 1, 0, 0, 0, 0);
        step("cc_t2", 1, 0, 0, 0, 0);
        step("cc_t3", 1, 0, 0, 0, 0);
        step("cc_coll", 1, 0, 0, 0, 1);
        idle("cc_hold", 2);
        step("cc_clear", 0, 0, 0, 0, 1);

        // async reset mid-RUN at remaining=7
        cfg(0, 0, 10);
        step("rst_start", 0, 0, 1, 0, 0);
        for (int k = 0; k < 3; k++) step("rst_tick", 1, 0, 0, 0, 0);
        chk("rst_pre_rem", 32'(tif.remaining), 7);
        rstnn = 1'b0;
        #2;
        check_zero("rst_async");
        model_reset();
        #4;
        rstnn = 1'b1;

        // zero timeout ignored; restart during RUN; cfg change ignored mid-run
        cfg(0, 0, 0);
        step("z_start0", 0, 0, 1, 0, 0);
        cfg(0, 0, 6);
        step("z_start6", 0, 0, 1, 0, 0);
        for (int k = 0; k < 4; k++) step("z_tick", 1, 0, 0, 0, 0);
        cfg(0, 0, 4);
        npulse = 0;
        step("z_restart", 0, 0, 1, 0, 0);
        chk("z_restart_rem", 32'(tif.remaining), 4);
        cfg(1, 1, 9);
        for (int k = 0; k < 4; k++) step("z_run", 1, 0, 0, 0, 0);
        chk("z_npulse", npulse, 1);
        idle("z_done", 2);

        // start beats the expiring tick: reload, no pulse
        cfg(0, 0, 3);
        step("sb_start", 0, 0, 1, 0, 0);
        step("sb_t1", 1, 0, 0, 0, 0);
        step("sb_t2", 1, 0, 0, 0, 0);
        npulse = 0;
        step("sb_coll", 1, 0, 1, 0, 0);
        chk("sb_npulse", npulse, 0);
        step("sb_startstop", 0, 0, 1, 1, 0);
        idle("sb_end", 2);

        if (sbq.size() != 0) chk("sb_queue_empty", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
